// File: rtl/multi_channel_thermometer_if.sv
// multi_channel_thermometer_if: scan control, ADC handshake and result bus of the multi-channel thermometer
interface multi_channel_thermometer_if #(
  parameter int ADC_W = 10,
  parameter int DEG_W = 7,
  parameter int CH_N  = 4
);
  localparam int CH_W = CH_N > 1 ? $clog2(CH_N) : 1;
  logic              START_I;
  logic [DEG_W-1:0]  ALARM_THR_I;
  logic              SAMPLE_REQ_O;
  logic [CH_W-1:0]   SAMPLE_CH_O;
  logic              SAMPLE_ACK_I;
  logic [ADC_W-1:0]  ANALOG_IN_I;
  logic [DEG_W-1:0]  DEGREE_O;
  logic [CH_W-1:0]   DEGREE_CH_O;
  logic              VALID_O;
  logic              BUSY_O;
  logic [CH_N-1:0]   ALARM_O;
  modport slave (
    input  START_I, ALARM_THR_I, SAMPLE_ACK_I, ANALOG_IN_I,
    output SAMPLE_REQ_O, SAMPLE_CH_O, DEGREE_O, DEGREE_CH_O, VALID_O, BUSY_O, ALARM_O
  );
  modport master (
    output START_I, ALARM_THR_I, SAMPLE_ACK_I, ANALOG_IN_I,
    input  SAMPLE_REQ_O, SAMPLE_CH_O, DEGREE_O, DEGREE_CH_O, VALID_O, BUSY_O, ALARM_O
  );
endinterface

// File: rtl/multi_channel_thermometer.sv
// multi_channel_thermometer: scans CH_N ADC channels, averages 2^AVG_LOG2 samples each, converts to degrees C
// Optional per-channel threshold alarms are built when THERMO_ALARM_EN is defined.
module multi_channel_thermometer #(
  parameter int ADC_W    = 10,
  parameter int DEG_W    = 7,
  parameter int CH_N     = 4,
  parameter int MAX_TEMP = 100,
  parameter int AVG_LOG2 = 2
) (
  input logic                          CLK_I,
  input logic                          RST_N_I,
  multi_channel_thermometer_if.slave   bus
);
  localparam int CH_W  = CH_N > 1 ? $clog2(CH_N) : 1;
  localparam int NS    = 1 << AVG_LOG2;
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int PW    = ADC_W + $clog2(MAX_TEMP + 1);
  typedef enum logic [1:0] {IDLE, REQ, CALC, OUT} state_t;
  state_t            state_q, state_d;
  logic              start_q;
  logic              trig;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DEG_W-1:0]  degree_q, degree_d;
  logic [CH_W-1:0]   degree_ch_q, degree_ch_d;
  logic [ADC_W-1:0]  avg;
  logic [PW-1:0]     prod;
  assign trig = bus.START_I & ~start_q;
  assign avg  = ADC_W'(acc_q >> AVG_LOG2);
  // full-width product so the divide sees every bit
  assign prod = PW'(avg) * PW'(MAX_TEMP);
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    degree_d    = degree_q;
    degree_ch_d = degree_ch_q;
    case (state_q)
      IDLE: if (trig) begin
        state_d = REQ;
        ch_d    = '0;
        cnt_d   = '0;
        acc_d   = '0;
      end
      REQ: if (bus.SAMPLE_ACK_I) begin
        acc_d   = acc_q + ACC_W'(bus.ANALOG_IN_I);
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(NS - 1) ? CALC : REQ;
      end
      CALC: begin
        degree_d    = DEG_W'(prod / PW'((1 << ADC_W) - 1));
        degree_ch_d = ch_q;
        state_d     = OUT;
      end
      OUT: begin
        state_d = ch_q == CH_W'(CH_N - 1) ? IDLE : REQ;
        ch_d    = ch_q == CH_W'(CH_N - 1) ? ch_q : ch_q + 1'b1;
        cnt_d   = '0;
        acc_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      ch_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      degree_q    <= '0;
      degree_ch_q <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= bus.START_I;
      ch_q        <= ch_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      degree_q    <= degree_d;
      degree_ch_q <= degree_ch_d;
    end
  end
  assign bus.SAMPLE_REQ_O = state_q == REQ;
  assign bus.SAMPLE_CH_O  = ch_q;
  assign bus.VALID_O      = state_q == OUT;
  assign bus.BUSY_O       = state_q != IDLE;
  assign bus.DEGREE_O     = degree_q;
  assign bus.DEGREE_CH_O  = degree_ch_q;
`ifdef THERMO_ALARM_EN
  logic [DEG_W-1:0] thr_q, thr_d;
  logic [CH_N-1:0]  alarm_q, alarm_d;
  always_comb begin
    thr_d   = state_q == IDLE && trig ? bus.ALARM_THR_I : thr_q;
    alarm_d = alarm_q;
    if (state_q == OUT) alarm_d[ch_q] = degree_q >= thr_q;
  end
  always_ff @(posedge CLK_I) begin
    if (!RST_N_I) begin
      thr_q   <= '0;
      alarm_q <= '0;
    end else begin
      thr_q   <= thr_d;
      alarm_q <= alarm_d;
    end
  end
  assign bus.ALARM_O = alarm_q;
`else
  logic unused_thr;
  assign unused_thr  = ^bus.ALARM_THR_I;
  assign bus.ALARM_O = '0;
`endif
endmodule

// File: tb/tb_multi_channel_thermometer.sv
// tb_multi_channel_thermometer: randomized scans checked against an arithmetic model of averaging and conversion
module tb_multi_channel_thermometer;
  localparam int ADC_W    = 10;
  localparam int DEG_W    = 7;
  localparam int CH_N     = 4;
  localparam int MAX_TEMP = 100;
  localparam int AVG_LOG2 = 2;
  localparam int NS       = 1 << AVG_LOG2;
  localparam int FULL     = (1 << ADC_W) - 1;
`ifdef THERMO_ALARM_EN
  localparam bit ALARM_EN = 1'b1;
`else
  localparam bit ALARM_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  multi_channel_thermometer_if #(.ADC_W(ADC_W), .DEG_W(DEG_W), .CH_N(CH_N)) bus ();
  multi_channel_thermometer #(
    .ADC_W(ADC_W), .DEG_W(DEG_W), .CH_N(CH_N), .MAX_TEMP(MAX_TEMP), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .CLK_I(clk),
    .RST_N_I(rst_n),
    .bus(bus)
  );
  int samp [CH_N][NS];
  int idx [CH_N];
  int mode = 0;
  int cyc = 0;
  int thr = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [CH_N-1:0] alarm_exp = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int exp_deg(input int c);
    int s = 0;
    for (int k = 0; k < NS; k++) s += samp[c][k];
    return (s / NS) * MAX_TEMP / FULL;
  endfunction
  // ADC front-end: acks per mode, spurious acks with junk data while no request is pending
  initial begin
    int c;
    bus.SAMPLE_ACK_I = 1'b0;
    bus.ANALOG_IN_I  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!bus.BUSY_O) foreach (idx[i]) idx[i] = 0;
      if (bus.SAMPLE_REQ_O && (mode == 0 || (mode == 1 && cyc % 3 == 0) ||
                               (mode == 2 && $urandom_range(0, 1) == 1))) begin
        c = int'(bus.SAMPLE_CH_O);
        bus.SAMPLE_ACK_I = 1'b1;
        bus.ANALOG_IN_I  = ADC_W'(idx[c] < NS ? samp[c][idx[c]] : 0);
        if (idx[c] < NS) idx[c]++;
      end else if (!bus.SAMPLE_REQ_O) begin
        bus.SAMPLE_ACK_I = mode == 2 && $urandom_range(0, 3) == 0;
        bus.ANALOG_IN_I  = ADC_W'($urandom);
      end else begin
        bus.SAMPLE_ACK_I = 1'b0;
        bus.ANALOG_IN_I  = '0;
      end
    end
  end
  task automatic start_scan(input int t, input bit hold);
    thr = t;
    bus.ALARM_THR_I = DEG_W'(t);
    bus.START_I = 1'b1;
    @(negedge clk);
    check("busy_rise", 32'(bus.BUSY_O), 1);
    check("req_rise", 32'(bus.SAMPLE_REQ_O), 1);
    check("req_ch0", 32'(bus.SAMPLE_CH_O), 0);
    if (!hold) bus.START_I = 1'b0;
  endtask
  task automatic collect(input bit glitch, input bit tcheck);
    int n = 0;
    int k = 1;
    int reqlow = 0;
    while (n < CH_N && k < 5000) begin
      if (!bus.SAMPLE_REQ_O) reqlow++;
      if (glitch && k == 3) bus.START_I = 1'b0;
      if (glitch && k == 8) bus.START_I = 1'b1;
      if (bus.VALID_O) begin
        check("deg_ch", 32'(bus.DEGREE_CH_O), n);
        check("degree", 32'(bus.DEGREE_O), exp_deg(n));
        if (tcheck) check("valid_cycle", k, (NS + 2) * (n + 1));
        alarm_exp[n] = exp_deg(n) >= thr;
        n++;
      end
      if (n < CH_N) begin
        @(negedge clk);
        k++;
      end
    end
    check("valid_count", n, CH_N);
    check("req_gaps", reqlow, 2 * CH_N);
    @(negedge clk);
    check("busy_fall", 32'(bus.BUSY_O), 0);
    check("alarm", 32'(bus.ALARM_O), 32'(ALARM_EN ? alarm_exp : '0));
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.BUSY_O), 0);
    check({tag, "_req"}, 32'(bus.SAMPLE_REQ_O), 0);
    check({tag, "_valid"}, 32'(bus.VALID_O), 0);
    check({tag, "_degree"}, 32'(bus.DEGREE_O), 0);
    check({tag, "_deg_ch"}, 32'(bus.DEGREE_CH_O), 0);
    check({tag, "_alarm"}, 32'(bus.ALARM_O), 0);
  endtask
  initial begin
    int b, v, w;
    bus.START_I = 1'b0;
    bus.ALARM_THR_I = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    check("reset_sample_ch", 32'(bus.SAMPLE_CH_O), 0);
    rst_n = 1'b1;
    @(negedge clk);
    foreach (samp[c, k]) samp[c][k] = FULL;
    start_scan(50, 0);
    collect(0, 1);
    foreach (samp[c, k]) samp[c][k] = c == 2 ? 300 : c == 3 ? 0 : FULL;
    samp[1][0] = 500; samp[1][1] = 520; samp[1][2] = 510; samp[1][3] = 518;
    start_scan(50, 0);
    collect(0, 1);
    mode = 1;
    start_scan(50, 0);
    collect(0, 0);
    mode = 0;
    foreach (samp[0][k]) samp[0][k] = 0;
    start_scan(50, 0);
    collect(0, 1);
    mode = 2;
    repeat (6) begin
      foreach (samp[c, k]) samp[c][k] = int'($urandom_range(0, FULL));
      start_scan(int'($urandom_range(0, MAX_TEMP)), 0);
      collect(0, 0);
    end
    mode = 0;
    start_scan(40, 1);
    collect(1, 1);
    b = 0;
    repeat (10) begin
      @(negedge clk);
      b += int'(bus.BUSY_O);
    end
    check("no_retrigger", b, 0);
    bus.START_I = 1'b0;
    @(negedge clk);
    start_scan(40, 0);
    collect(0, 1);
    start_scan(60, 0);
    w = 0;
    while (!(bus.SAMPLE_REQ_O && bus.SAMPLE_CH_O == 2) && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("reach_ch2", 32'(w < 200), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_zero("midrst");
    alarm_exp = '0;
    v = 0;
    repeat (40) begin
      @(negedge clk);
      v += int'(bus.VALID_O);
    end
    check("no_valid_after_rst", v, 0);
    start_scan(60, 0);
    collect(0, 1);
    rst_n = 1'b0;
    bus.START_I = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    alarm_exp = '0;
    @(negedge clk);
    check("start_at_reset", 32'(bus.BUSY_O), 1);
    bus.START_I = 1'b0;
    collect(0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/multi_channel_thermometer.md
# multi_channel_thermometer

Parametrised successor to the single-channel digital thermometer. On a rising edge of `START_I` it scans `CH_N` sensor channels in order, 0 to `CH_N-1`. For each channel it fetches `2^AVG_LOG2` ADC samples over a req/ack handshake, averages them, and converts the average to whole degrees Celsius. Each channel's result is published with a one-cycle valid pulse. The block sits between the ADC sampling front-end and the display/alarm logic.

## Interface
- `ADC_W`, 10, ADC sample width
- `DEG_W`, 7, degree output width; must hold `MAX_TEMP`
- `CH_N`, 4, number of channels (1–16)
- `MAX_TEMP`, 100, degrees at full-scale code `2^ADC_W-1`
- `AVG_LOG2`, 2, log2 of samples averaged per channel (0–4)
- `CLK_I`  in  1  clock; all logic on rising edge
- `RST_N_I`  in  1  reset, synchronous, active-low
- `START_I`  in  1  scan trigger; acts on rising edge only
- `ALARM_THR_I`  in  DEG_W  alarm threshold in degrees; captured on the start edge
- `SAMPLE_REQ_O`  out  1  sample request to ADC front-end
- `SAMPLE_CH_O`  out  clog2(CH_N) (min 1)  channel being requested
- `SAMPLE_ACK_I`  in  1  front-end ack; `ANALOG_IN_I` is valid in the same cycle
- `ANALOG_IN_I`  in  ADC_W  sample data
- `DEGREE_O`  out  DEG_W  latest converted temperature
- `DEGREE_CH_O`  out  clog2(CH_N) (min 1)  channel of `DEGREE_O`
- `VALID_O`  out  1  one-cycle pulse: `DEGREE_O`/`DEGREE_CH_O` new
- `BUSY_O`  out  1  scan in progress
- `ALARM_O`  out  CH_N  per-channel over-threshold flags

## Operation
- Reset values: all outputs 0; FSM in `IDLE`; edge register 0; channel, sample and accumulator counters 0.
- Edge detect: trigger = `START_I & !start_d`. Because `start_d` resets to 0, a `START_I` held high at reset release counts as an edge.
- `IDLE`: on trigger, capture `ALARM_THR_I`, set channel to 0, clear accumulator, set `BUSY_O`=1, go to `REQ`. Triggers in any other state are ignored.
- `REQ`: `SAMPLE_REQ_O`=1 and `SAMPLE_CH_O`=channel. Each cycle with `SAMPLE_ACK_I`=1 adds `ANALOG_IN_I` to the accumulator and increments the sample count. On the `2^AVG_LOG2`-th ack, go to `CALC`. `REQ_O` stays high across back-to-back samples.
- `CALC`: avg = acc >> `AVG_LOG2` (width `ADC_W`). Register deg = floor(avg*`MAX_TEMP`/(2^`ADC_W`-1)). The product is full width (`ADC_W`+clog2(`MAX_TEMP`+1)), with no truncation before the divide. Result is at most `MAX_TEMP`. Go to `OUT`.
- `OUT`: `VALID_O`=1 for one cycle, with `DEGREE_O`=deg and `DEGREE_CH_O`=channel. If channel = `CH_N-1`: `BUSY_O`=0 and go to `IDLE`. Otherwise: channel+1, clear accumulator and count, go to `REQ`.
- `DEGREE_O` and `DEGREE_CH_O` hold their value until the next `OUT`.
- `SAMPLE_ACK_I` outside `REQ` is ignored.
- An unreachable FSM encoding returns to `IDLE` next cycle.
- `RST_N_I`=0 mid-scan: next edge restores all reset values. `SAMPLE_REQ_O` drops, no `VALID_O` is issued, and partial accumulation is discarded.

## Timing
- Trigger edge at cycle t: `BUSY_O` and `SAMPLE_REQ_O` high at t+1.
- The last ack of a channel at cycle c gives `CALC` at c+1, `VALID_O` at c+2, and `REQ_O` for the next channel at c+3.
- With ack held high: per-channel latency is `2^AVG_LOG2`+2 cycles. A full scan takes `CH_N`·(`2^AVG_LOG2`+2) cycles from t+1.
- `BUSY_O` falls in the same cycle as the final `VALID_O` is registered, i.e. it is low from the cycle after the last `OUT`. The earliest re-trigger is accepted in `IDLE`.
- Ack stalls extend `REQ` indefinitely. There is no timeout.

## Configuration
- Macro `THERMO_ALARM_EN`.
- Defined: on each `OUT` cycle, `ALARM_O[channel]` is set to (deg ≥ captured threshold) and the other bits hold. Flags persist across scans until that channel is re-measured or reset.
- Undefined: no threshold register and no compare logic; `ALARM_O` is tied to 0. `ALARM_THR_I` is unused.

## Test plan
- Defaults, ack held high, samples 1023 on all channels -> 4 `VALID_O` pulses, `DEGREE_O`=100, `DEGREE_CH_O`=0,1,2,3 each 6 cycles apart; `BUSY_O` low after the last pulse.
- Channel 1 samples 500, 520, 510, 518 (avg 512) -> ch1 `DEGREE_O`=50. Channel 2 all 300 -> 29. Channel 3 all 0 -> 0.
- Ack asserted only every 3rd cycle -> same results. `REQ_O` stays high throughout; `VALID_O` timing is shifted by the stalls.
- `START_I` pulsed again mid-scan and held high at scan end -> no restart until `START_I` goes low then high.
- `RST_N_I` low for 1 cycle during ch2 `REQ` -> next cycle all outputs 0, no further `VALID_O`; a new start scans from ch0.
- With `THERMO_ALARM_EN`, threshold 50, channel temps 100/50/29/0 -> `ALARM_O`=4'b0011. A rescan with ch0 at 0 -> 4'b0010. Without the macro -> `ALARM_O`=0.
